// File: rtl/display_scan_controller.sv
// Time-multiplexed scan driver for a 4-digit seven-segment display.
// Commits new display values only at frame boundaries; blanks between digits.
module display_scan_controller #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic        lz_blank,
  input  logic [3:0]  digit_enable,
  output logic [1:0]  selection,
  output logic [15:0] displayInfo,
  output logic [3:0]  anode,
  output logic        load_ack,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {
    BLANK,
    DRIVE
  } phase_t;

  phase_t         state, state_d;
  logic [CW-1:0]  cnt;
  logic [15:0]    pending;
  logic           pend_valid;
  logic           slot_end;
  logic           frame_end;
  logic [3:0]     suppress;
  logic [3:0]     anode_d;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (selection == 2'd3);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      BLANK:   if (cnt == BLANK_LAST) state_d = DRIVE;
      DRIVE:   if (slot_end)          state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // A digit is suppressed when it and every more significant nibble are zero.
  always_comb begin
    suppress    = 4'b0000;
    suppress[3] = lz_blank && (displayInfo[15:12] == 4'h0);
    suppress[2] = suppress[3] && (displayInfo[11:8] == 4'h0);
    suppress[1] = suppress[2] && (displayInfo[7:4] == 4'h0);
  end

  // Computed from the next phase so the registered anode lines up with the FSM state.
  // Selection and displayInfo only change when entering BLANK, so their current values suffice.
  always_comb begin
    anode_d = 4'b1111;
    if (state_d == DRIVE && digit_enable[selection] && !suppress[selection])
      anode_d[selection] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      selection   <= 2'd0;
      state       <= BLANK;
      anode       <= 4'b1111;
      displayInfo <= 16'h0000;
      pending     <= 16'h0000;
      pend_valid  <= 1'b0;
      load_ack    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + CW'(1);
      state      <= state_d;
      anode      <= anode_d;
      load_ack   <= 1'b0;
      frame_done <= frame_end;
      if (slot_end)
        selection <= selection + 2'd1;

      if (frame_end) begin
        // A load in the boundary cycle bypasses pending and is committed directly.
        if (load || pend_valid) begin
          displayInfo <= load ? data_in : pending;
          load_ack    <= 1'b1;
        end
        pend_valid <= 1'b0;
      end else if (load) begin
        pending    <= data_in;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexed scan driver for the 4-digit seven-segment display. It generates the `selection` digit index and the `displayInfo` word consumed by the `sevenSegmenDisplay` decoder, and drives the matching active-low digit anodes. The block also holds a frame-synchronous display register, so a new 16-bit value is committed only at a frame boundary, plus inter-digit blanking against ghosting and optional leading-zero suppression. It sits between the user/system logic and the segment decoder at the board pins.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK_CYCLES`, default 500: cycles at the start of each slot with all anodes off; legal range 1 ≤ BLANK_CYCLES < REFRESH_DIV.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  16  new display value, four hex nibbles; digit 0 = [3:0].
- `load`  in  1  one-cycle strobe that captures `data_in` as pending.
- `lz_blank`  in  1  enables leading-zero suppression; sampled live.
- `digit_enable`  in  4  per-digit enable, bit k = digit k; sampled live.
- `selection`  out  2  current digit index; feeds the decoder.
- `displayInfo`  out  16  committed display word; feeds the decoder.
- `anode`  out  4  active-low digit enables; bit k = digit k.
- `load_ack`  out  1  one-cycle pulse when a pending value is committed.
- `frame_done`  out  1  one-cycle pulse on the first cycle of every frame.

## Operation
- Registers:
  - prescaler `cnt`, range 0..REFRESH_DIV-1;
  - 2-bit `selection`;
  - phase FSM with states BLANK and DRIVE;
  - 16-bit `pending` value plus a `pend_valid` flag;
  - `displayInfo`.
- Reset values, applied on the cycle after `reset` is sampled high:
  - `cnt` = 0, `selection` = 0, FSM = BLANK;
  - `anode` = 4'b1111, `displayInfo` = 16'h0000;
  - `pending` = 0, `pend_valid` = 0;
  - `load_ack` = 0, `frame_done` = 0.
  - Reset mid-frame discards any pending load.
- Prescaler:
  - `cnt` increments every cycle.
  - At REFRESH_DIV-1 it wraps to 0 and `selection` advances mod 4 (3→0 wraps).
- FSM:
  - BLANK→DRIVE on the edge where `cnt` goes BLANK_CYCLES-1 → BLANK_CYCLES.
  - DRIVE→BLANK on the edge where `cnt` wraps to 0.
  - No other transitions.
- Anodes, registered and aligned to the FSM state:
  - In BLANK, `anode` = 4'b1111.
  - In DRIVE, only `anode[selection]` = 0, provided `digit_enable[selection]` = 1 and the digit is not suppressed. Otherwise 4'b1111.
- Leading-zero suppression:
  - Applies when `lz_blank` = 1.
  - Digit k (k = 1..3) is suppressed if every `displayInfo` nibble from digit 3 down to digit k is 4'h0.
  - Digit 0 is never suppressed.
  - Evaluated on the committed `displayInfo` only.
- Load:
  - `load` = 1 sets `pending` = `data_in` and `pend_valid` = 1.
  - A second load before commit overwrites `pending`; there is still only one commit.
- Commit:
  - Occurs on the frame-boundary edge, i.e. when `selection` goes 3→0.
  - If `pend_valid`: `displayInfo` ← `pending`, `pend_valid` ← 0, and `load_ack` pulses.
  - If `load` = 1 in the cycle before the boundary edge, `data_in` bypasses `pending` and is committed directly.
  - No commit occurs without a pending or bypassed value.
- `displayInfo` and `selection` never change on different edges within a boundary, so the decoder always sees a consistent word/index pair.

## Timing
- Slot length is REFRESH_DIV cycles; frame length is 4·REFRESH_DIV cycles.
- Per slot:
  - BLANK for exactly BLANK_CYCLES cycles (`cnt` 0..BLANK_CYCLES-1);
  - DRIVE for exactly REFRESH_DIV−BLANK_CYCLES cycles.
- The first frame starts on the first cycle after reset deasserts: `selection` = 0, `cnt` = 0.
  - `frame_done` is not pulsed for this initial frame.
  - It pulses on the first cycle of every later frame.
- `load_ack` and `frame_done` are high for exactly one cycle, coincident with the first cycle of the new frame, and only when a commit occurred (for `load_ack`).
- Load-to-display latency: from 1 up to 4·REFRESH_DIV cycles, depending on frame phase.
- `digit_enable` / `lz_blank` changes appear on `anode` one cycle later, during DRIVE.

## Test plan
Run with REFRESH_DIV = 8, BLANK_CYCLES = 2.
- Reset, then run for 32 cycles → `selection` steps 0,1,2,3 every 8 cycles. Each slot shows `anode` = 4'b1111 for 2 cycles, then the digit's bit low for 6 cycles (4'b1110, 4'b1101, 4'b1011, 4'b0111).
- Load 16'h1234 mid-slot 1 → `displayInfo` stays 16'h0000 until the 3→0 edge, then becomes 16'h1234 with one `load_ack` pulse coincident with `frame_done`.
- Load 16'hAAAA then 16'h00C5 in the same frame → a single commit of 16'h00C5 and one `load_ack`.
- Load asserted in the last cycle of slot 3 → that `data_in` is committed at the immediately following boundary.
- `displayInfo` = 16'h0005, `lz_blank` = 1 → digits 3, 2 and 1 are never driven and digit 0 is driven. With `lz_blank` = 0, all four are driven. With `displayInfo` = 16'h0000, only digit 0 is driven.
- `digit_enable` = 4'b0101 → digits 1 and 3 are never driven. Assert `reset` mid-slot 2 with a load pending → next cycle `anode` = 4'b1111 and `selection` = 0; the pending value is never committed.
